// File: rtl/riscv_pkg.sv
// Shared RV32I constants: datapath width and the base opcode map.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch <-> decode link: fetched PC/instruction forward, redirect request back.
interface decode_stage_if;
  import riscv_pkg::*;

  logic [XLEN-1:0] pc_i;
  logic [31:0]     instr_i;
  logic            update_i;
  logic [XLEN-1:0] jump_pc_o;
  logic            jump_pc_valid_o;

  // Fetch side: presents instructions, follows redirects.
  modport master (
    output pc_i,
    output instr_i,
    output update_i,
    input  jump_pc_o,
    input  jump_pc_valid_o
  );

  // Decode side: consumes instructions, issues redirects.
  modport slave (
    input  pc_i,
    input  instr_i,
    input  update_i,
    output jump_pc_o,
    output jump_pc_valid_o
  );

endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, 32x32 register file with write-through
// bypass, immediate generation, and jump/branch resolution with redirect.
module decode_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            stallD_i,
  input  logic            flushD_i,
  decode_stage_if.slave   fetch_if,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] imm_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic            funct7b5_o,
  output logic            illegal_o
);

  // Immediate formats, all sign-extended from instruction bit 31
  function automatic logic [XLEN-1:0] imm_i_fmt(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [XLEN-1:0] imm_s_fmt(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [XLEN-1:0] imm_b_fmt(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_u_fmt(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_j_fmt(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] rf_q [32];

  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic [4:0]             rs1_addr;
  logic [4:0]             rs2_addr;
  logic [XLEN-1:0]        rs1_data;
  logic [XLEN-1:0]        rs2_data;
  logic signed [XLEN-1:0] rs1_sdata;
  logic signed [XLEN-1:0] rs2_sdata;
  logic [XLEN-1:0]        imm;
  logic                   is_jal;
  logic                   is_jalr;
  logic                   is_branch;
  logic                   opc_known;
  logic                   illegal;
  logic                   br_taken;
  logic                   jump_req;
  logic [XLEN-1:0]        jump_target;

  assign opcode    = instr_q[6:0];
  assign funct3    = instr_q[14:12];
  assign rs1_addr  = instr_q[19:15];
  assign rs2_addr  = instr_q[24:20];
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign rs1_sdata = rs1_data;
  assign rs2_sdata = rs2_data;

  // IF/ID register: flush and redirect bubble, stall holds, otherwise load
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else if (flushD_i || jump_req) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (!stallD_i) begin
      valid_q <= fetch_if.update_i;
      pc_q    <= fetch_if.pc_i;
      instr_q <= fetch_if.instr_i;
    end
  end

  // Register file write port; x0 is never written
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en_i && (wb_rd_i != 5'd0)) begin
      rf_q[wb_rd_i] <= wb_data_i;
    end
  end

  // Operand read with write-through so write-back is visible the same cycle
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != 5'd0) begin
      rs1_data = (wb_en_i && (wb_rd_i == rs1_addr)) ? wb_data_i : rf_q[rs1_addr];
    end
    if (rs2_addr != 5'd0) begin
      rs2_data = (wb_en_i && (wb_rd_i == rs2_addr)) ? wb_data_i : rf_q[rs2_addr];
    end
  end

  // Immediate format chosen by opcode; unknown formats give zero
  always_comb begin
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm = imm_i_fmt(instr_q);
      OPC_STORE:                      imm = imm_s_fmt(instr_q);
      OPC_BRANCH:                     imm = imm_b_fmt(instr_q);
      OPC_LUI, OPC_AUIPC:             imm = imm_u_fmt(instr_q);
      OPC_JAL:                        imm = imm_j_fmt(instr_q);
      default:                        imm = '0;
    endcase
  end

  // Illegal detection: unknown opcode, reserved branch funct3, or bad JALR funct3
  always_comb begin
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: opc_known = 1'b1;
      default:                                             opc_known = 1'b0;
    endcase
    illegal = valid_q && (!opc_known
                          || (is_branch && (funct3[2:1] == 2'b01))
                          || (is_jalr && (funct3 != 3'b000)));
  end

  // Branch condition evaluated on the bypassed operands
  always_comb begin
    case (funct3)
      3'b000:  br_taken = (rs1_data == rs2_data);
      3'b001:  br_taken = (rs1_data != rs2_data);
      3'b100:  br_taken = (rs1_sdata < rs2_sdata);
      3'b101:  br_taken = (rs1_sdata >= rs2_sdata);
      3'b110:  br_taken = (rs1_data < rs2_data);
      3'b111:  br_taken = (rs1_data >= rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  // Redirect target; non-control instructions point at the fall-through PC
  always_comb begin
    if (is_jal) begin
      jump_target = pc_q + imm;
    end else if (is_jalr) begin
      jump_target = (rs1_data + imm) & ~XLEN'(1);
    end else if (is_branch) begin
      jump_target = pc_q + imm;
    end else begin
      jump_target = pc_q + XLEN'(4);
    end
  end

  // No redirect while stalled: the operands may not be final yet
  assign jump_req = valid_q && !stallD_i && !illegal
                    && (is_jal || is_jalr || (is_branch && br_taken));

  assign fetch_if.jump_pc_o       = jump_target;
  assign fetch_if.jump_pc_valid_o = jump_req;

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign rs1_addr_o = rs1_addr;
  assign rs2_addr_o = rs2_addr;
  assign rd_addr_o  = instr_q[11:7];
  assign rs1_data_o = rs1_data;
  assign rs2_data_o = rs2_data;
  assign imm_o      = imm;
  assign opcode_o   = opcode;
  assign funct3_o   = funct3;
  assign funct7b5_o = instr_q[30];
  assign illegal_o  = illegal;

endmodule
